// File: rtl/regfile_scoreboard.sv
// Integer regfile (2R/1W, x0 = 0) with per-register busy scoreboard and a one-entry-per-cycle flush FSM.
// Reads are combinational. Writes and issues are dropped while Ready=0. Optional `REGFILE_BYPASS_EN` adds write-first read forwarding.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] RegWriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRd,
  input  logic              ClearReq,
  output logic              Ready
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic {
    READY = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;

  logic accept;
  logic wr_en;
  logic iss_en;
  logic byp1;
  logic byp2;

  assign Ready  = (state_q == READY);
  // A ClearReq cycle swallows any write/issue presented alongside it.
  assign accept = Ready & ~ClearReq;
  assign wr_en  = RegWrite & accept & (WriteRegister != '0);
  assign iss_en = IssueValid & accept & (IssueRd != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    case (state_q)
      READY: begin
        if (wr_en) begin
          mem_d[WriteRegister]  = RegWriteData;
          busy_d[WriteRegister] = 1'b0;
        end
        // Applied after the write so a same-index issue leaves the register busy.
        if (iss_en) begin
          busy_d[IssueRd] = 1'b1;
        end
        if (ClearReq) begin
          state_d = FLUSH;
          cnt_d   = ONE;
        end
      end
      FLUSH: begin
        mem_d[cnt_q]  = '0;
        busy_d[cnt_q] = 1'b0;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = READY;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = READY;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= READY;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = RegWrite & Ready & (WriteRegister != '0) & (WriteRegister == ReadRegister1);
  assign byp2 = RegWrite & Ready & (WriteRegister != '0) & (WriteRegister == ReadRegister2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (byp1) begin
      ReadData1 = RegWriteData;
    end else if (ReadRegister1 != '0) begin
      ReadData1 = mem_q[ReadRegister1];
    end
    if (byp2) begin
      ReadData2 = RegWriteData;
    end else if (ReadRegister2 != '0) begin
      ReadData2 = mem_q[ReadRegister2];
    end
  end

  // Busy reflects registered state only; no forwarding of this cycle's issue/write.
  assign Busy1 = (ReadRegister1 != '0) & busy_q[ReadRegister1];
  assign Busy2 = (ReadRegister2 != '0) & busy_q[ReadRegister2];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default build; bypass expectations follow REGFILE_BYPASS_EN).
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] RegWriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Busy1;
  logic        Busy2;
  logic        IssueValid;
  logic [4:0]  IssueRd;
  logic        ClearReq;
  logic        Ready;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .RegWriteData(RegWriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Busy1(Busy1), .Busy2(Busy2),
    .IssueValid(IssueValid), .IssueRd(IssueRd),
    .ClearReq(ClearReq), .Ready(Ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    RegWrite      = 1'b1;
    WriteRegister = idx;
    RegWriteData  = val;
    step();
    RegWrite      = 1'b0;
  endtask

  int  flush_cycles;
  bit  saw_ff;

  initial begin
    reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; RegWriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0; IssueValid = 1'b0; IssueRd = '0; ClearReq = 1'b0;

    // 1: reset state
    #13;
    check("ready_in_reset", 32'(Ready), 32'd1);
    step();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      check("rst_rd1", ReadData1, 32'd0);
      check("rst_rd2", ReadData2, 32'd0);
      check("rst_busy1", 32'(Busy1), 32'd0);
    end
    check("rst_ready", 32'(Ready), 32'd1);

    // 2: basic write, x0 drop
    step();
    write_reg(5'd5, 32'hDEADBEEF);
    write_reg(5'd0, 32'h00001234);
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd0; #1;
    check("x5_data", ReadData1, 32'hDEADBEEF);
    check("x0_data", ReadData2, 32'd0);

    // 3: scoreboard
    IssueValid = 1'b1; IssueRd = 5'd7; ReadRegister1 = 5'd7; #1;
    check("busy_no_fwd", 32'(Busy1), 32'd0);
    step();
    IssueValid = 1'b0; #1;
    check("busy_after_issue", 32'(Busy1), 32'd1);
    IssueValid = 1'b1; IssueRd = 5'd7;
    write_reg(5'd7, 32'h55);
    IssueValid = 1'b0; #1;
    check("busy_issue_wins", 32'(Busy1), 32'd1);
    check("x7_data_55", ReadData1, 32'h55);
    write_reg(5'd7, 32'h66);
    #1;
    check("busy_cleared_wb", 32'(Busy1), 32'd0);
    check("x7_data_66", ReadData1, 32'h66);

    // 4: flush
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    ReadRegister1 = 5'd3; ReadRegister2 = 5'd31; #1;
    check("fill_x3", ReadData1, 32'd3);
    check("fill_x31", ReadData2, 32'd31);
    IssueValid = 1'b1; IssueRd = 5'd12;
    step();
    IssueValid = 1'b0; ReadRegister2 = 5'd12; #1;
    check("busy_x12", 32'(Busy2), 32'd1);
    ReadRegister2 = 5'd31;
    ClearReq = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; RegWriteData = 32'hFF;
    IssueValid = 1'b1; IssueRd = 5'd5; #1;
    check("ready_before_flush", 32'(Ready), 32'd1);
    step();
    ClearReq = 1'b0;
    flush_cycles = 0;
    saw_ff = 1'b0;
    while (!Ready && flush_cycles < 100) begin
      if (flush_cycles == 0) check("flush_partial_x31", ReadData2, 32'd31);
      if (ReadData1 == 32'hFF) saw_ff = 1'b1;
      flush_cycles++;
      step();
    end
    RegWrite = 1'b0; IssueValid = 1'b0;
    check("flush_len", 32'(flush_cycles), 32'd31);
    check("x3_never_ff", 32'(saw_ff), 32'd0);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); #1;
      check("post_flush_data", ReadData1, 32'd0);
      check("post_flush_busy", 32'(Busy1), 32'd0);
    end

    // 5: reset aborts flush
    write_reg(5'd4, 32'h44);
    write_reg(5'd20, 32'h2020);
    IssueValid = 1'b1; IssueRd = 5'd25;
    step();
    IssueValid = 1'b0;
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    repeat (9) step();
    ReadRegister1 = 5'd4; ReadRegister2 = 5'd20; #1;
    check("mid_ready", 32'(Ready), 32'd0);
    check("mid_x4_cleared", ReadData1, 32'd0);
    check("mid_x20_kept", ReadData2, 32'h2020);
    ReadRegister1 = 5'd25; #1;
    check("mid_busy25", 32'(Busy1), 32'd1);
    reset = 1'b0; #1;
    check("abort_ready", 32'(Ready), 32'd1);
    check("abort_x20", ReadData2, 32'd0);
    check("abort_busy25", 32'(Busy1), 32'd0);
    step();
    reset = 1'b1;
    write_reg(5'd8, 32'h88);
    ReadRegister1 = 5'd8; #1;
    check("post_abort_write", ReadData1, 32'h88);

    // 6: same-cycle read of a written register
    RegWrite = 1'b1; WriteRegister = 5'd9; RegWriteData = 32'hA5A5A5A5; ReadRegister2 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rd2", ReadData2, 32'hA5A5A5A5);
`else
    check("bypass_rd2", ReadData2, 32'd0);
`endif
    step();
    RegWrite = 1'b0; #1;
    check("x9_after_edge", ReadData2, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
